// File: rtl/vector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vector_pkg
//  Description : Shared constants, state encoding and lane-packing helper
//                for the vector search memory (loader and search core).
//                Each 64-bit word holds LANES byte pairs. Pair k sits at
//                bits [16k+15:16k]: query byte low, candidate byte high.
//  Revision    : 1.0 - initial release
// ============================================================================
package vector_pkg;

    localparam int ADDR_W    = 12;
    localparam int LANES     = 4;
    localparam int MEM_DEPTH = 4096;
    localparam int DIM_MAX   = 252;
    localparam int WORD_W    = 64;
    localparam int LANE_W    = 16;
    localparam int Q_OFS     = 0;   // query byte offset inside a lane
    localparam int C_OFS     = 8;   // candidate byte offset inside a lane

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_QUERY = 3'd1,
        ST_CAND  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Interleave LANES query bytes with LANES candidate bytes into one word.
    // Byte k of each input is element base+k.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [8*LANES-1:0] q,
        input logic [8*LANES-1:0] c
    );
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < LANES; k++) begin
            w[LANE_W*k + Q_OFS +: 8] = q[8*k +: 8];
            w[LANE_W*k + C_OFS +: 8] = c[8*k +: 8];
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : vector_mem_loader_if
//  Description : Byte stream (valid/ready) plus vector RAM write port.
//                master : stream source / RAM side (drives s_valid, s_data)
//                slave  : loader (drives s_ready and the RAM write port)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vector_mem_loader_if;

    logic                          s_valid;
    logic [7:0]                    s_data;
    logic                          s_ready;
    logic                          mem_we;
    logic [vector_pkg::ADDR_W-1:0] mem_waddr;
    logic [vector_pkg::WORD_W-1:0] mem_wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_waddr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/vector_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : vector_word_packer
//  Description : Registers one interleaved RAM word per load strobe.
//  Ports       : clk, reset (async, active-high)
//                load      - capture q_bytes/c_bytes this cycle
//                q_bytes   - LANES query bytes, element base+k in byte k
//                c_bytes   - LANES candidate bytes, same ordering
//                mem_we    - one-cycle write strobe, cycle after load
//                mem_wdata - packed word, held until the next load
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_word_packer
    import vector_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [8*LANES-1:0]   q_bytes,
    input  logic [8*LANES-1:0]   c_bytes,
    output logic                 mem_we,
    output logic [WORD_W-1:0]    mem_wdata
);

    logic              we_q,    we_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;

    always_comb begin
        we_d    = load;
        wdata_d = wdata_q;
        if (load) begin
            wdata_d = pack_word(q_bytes, c_bytes);
        end
    end

    // Async reset so a reset mid-load kills the strobe immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: rtl/vector_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : vector_mem_loader
//  Description : Captures a query vector, then streams candidate vectors and
//                writes interleaved query/candidate words to the vector RAM
//                at sequential addresses starting from 0.
//  Ports       : clk, reset (async, active-high)
//                start_load, dim_size, vector_count - load request/config
//                bus (slave)   - byte stream in, RAM write port out
//                busy, done, cfg_err - status (done/cfg_err are pulses)
//                words_written - words written by the current/last load
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_mem_loader
    import vector_pkg::*;
#(
    parameter int ADDR_W = vector_pkg::ADDR_W,
    parameter int LANES  = vector_pkg::LANES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_load,
    input  logic [7:0]            dim_size,
    input  logic [9:0]            vector_count,
    vector_mem_loader_if.slave    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [ADDR_W-1:0]     words_written
);

    localparam int GRP_W = 8 * LANES;

    state_t            state_q, state_d;
    logic [7:0]        dim_q,   dim_d;
    logic [9:0]        vc_q,    vc_d;
    logic [7:0]        elem_q,  elem_d;
    logic [9:0]        vec_q,   vec_d;
    logic [GRP_W-1:0]  cand_q,  cand_d;
    logic [ADDR_W-1:0] wcnt_q,  wcnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              cfg_err_q, cfg_err_d;

    logic [7:0]        qbuf_q [256];
    logic              qbuf_we;

    logic              s_ready_w;
    logic              accept;
    logic              load;
    logic              last_elem;
    logic              last_vec;
    logic              cfg_bad;
    logic [15:0]       total;
    logic [7:0]        grp_base;
    logic [GRP_W-1:0]  q_bytes;

    // Words per vector is dim_size/4; total must fit in the RAM.
    assign total   = {6'd0, vector_count} * {10'd0, dim_size[7:2]};
    assign cfg_bad = (dim_size == 8'd0) || (dim_size[1:0] != 2'b00) ||
                     (total > 16'(MEM_DEPTH));

    assign s_ready_w = (state_q == ST_QUERY) || (state_q == ST_CAND);
    assign accept    = s_ready_w && bus.s_valid;
    assign last_elem = (elem_q == dim_q - 8'd1);
    assign last_vec  = (vec_q == vc_q - 10'd1);

    // The group's first element is elem_idx-3 when its 4th byte arrives.
    assign grp_base = {elem_q[7:2], 2'b00};

    for (genvar k = 0; k < LANES; k++) begin : g_qsel
        assign q_bytes[8*k +: 8] = qbuf_q[grp_base + 8'(k)];
    end

    always_comb begin
        state_d   = state_q;
        dim_d     = dim_q;
        vc_d      = vc_q;
        elem_d    = elem_q;
        vec_d     = vec_q;
        cand_d    = cand_q;
        wcnt_d    = wcnt_q;
        waddr_d   = waddr_q;
        cfg_err_d = 1'b0;
        qbuf_we   = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_load) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        dim_d   = dim_size;
                        vc_d    = vector_count;
                        elem_d  = 8'd0;
                        vec_d   = 10'd0;
                        wcnt_d  = '0;
                        state_d = (vector_count == 10'd0) ? ST_DONE : ST_QUERY;
                    end
                end
            end

            ST_QUERY: begin
                if (accept) begin
                    qbuf_we = 1'b1;
                    if (last_elem) begin
                        elem_d  = 8'd0;
                        state_d = ST_CAND;
                    end else begin
                        elem_d = elem_q + 8'd1;
                    end
                end
            end

            ST_CAND: begin
                if (accept) begin
                    // Newest byte enters at the top so byte 0 is the oldest.
                    cand_d = {bus.s_data, cand_q[GRP_W-1:8]};
                    if (elem_q[1:0] == 2'(LANES - 1)) begin
                        load    = 1'b1;
                        waddr_d = wcnt_q;
                        wcnt_d  = wcnt_q + 1'b1;
                    end
                    if (last_elem) begin
                        elem_d = 8'd0;
                        if (last_vec) begin
                            state_d = ST_FLUSH;
                        end else begin
                            vec_d = vec_q + 10'd1;
                        end
                    end else begin
                        elem_d = elem_q + 8'd1;
                    end
                end
            end

            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dim_q     <= 8'd0;
            vc_q      <= 10'd0;
            elem_q    <= 8'd0;
            vec_q     <= 10'd0;
            cand_q    <= '0;
            wcnt_q    <= '0;
            waddr_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dim_q     <= dim_d;
            vc_q      <= vc_d;
            elem_q    <= elem_d;
            vec_q     <= vec_d;
            cand_q    <= cand_d;
            wcnt_q    <= wcnt_d;
            waddr_q   <= waddr_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Query buffer is plain storage: always written before it is read.
    always_ff @(posedge clk) begin
        if (qbuf_we) begin
            qbuf_q[elem_q] <= bus.s_data;
        end
    end

    vector_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .q_bytes   (q_bytes),
        .c_bytes   (cand_d),
        .mem_we    (bus.mem_we),
        .mem_wdata (bus.mem_wdata)
    );

    assign bus.s_ready   = s_ready_w;
    assign bus.mem_waddr = waddr_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign cfg_err       = cfg_err_q;
    assign words_written = wcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_mem_loader
//  Description : Self-checking bench for vector_mem_loader. Expected RAM
//                words are built from the query/candidate arrays with plain
//                index arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_load;
    logic [7:0]  dim_size;
    logic [9:0]  vector_count;
    logic        busy, done, cfg_err;
    logic [11:0] words_written;

    vector_mem_loader_if bus ();

    vector_mem_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start_load    (start_load),
        .dim_size      (dim_size),
        .vector_count  (vector_count),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [11:0] a;
        logic [63:0] d;
    } wr_t;

    wr_t wq[$];
    wr_t ref_q[$];
    int  done_cnt  = 0;
    int  ready_cnt = 0;
    logic prev_we  = 1'b0;

    logic [7:0] qv [256];
    logic [7:0] cv [16384];

    typedef struct {
        int dim;
        int vc;
        int stall;
        bit err;
        int words;
    } vec_t;

    localparam int NT = 9;
    vec_t tbl [NT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write/strobe monitor.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wq.push_back('{bus.mem_waddr, bus.mem_wdata});
            check("we_back_to_back", 64'(prev_we), 64'd0);
        end
        if (done === 1'b1) done_cnt++;
        if (bus.s_ready === 1'b1) ready_cnt++;
        prev_we <= bus.mem_we;
    end

    task automatic fill_random();
        for (int i = 0; i < 256; i++) qv[i] = 8'($urandom);
        for (int i = 0; i < 16384; i++) cv[i] = 8'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int dim, input int vc);
        start_load   = 1'b1;
        dim_size     = 8'(dim);
        vector_count = 10'(vc);
        step();
        start_load   = 1'b0;
    endtask

    // Offers one byte, with random idle cycles first; returns once accepted.
    task automatic send_byte(input logic [7:0] b, input int stall_pct, output bit ok);
        ok = 1'b0;
        while (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'($urandom);
            step();
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        for (int w = 0; w < 20 && !ok; w++) begin
            ok = bus.s_ready;
            step();
        end
        bus.s_valid = 1'b0;
    endtask

    // Reference word: word i belongs to vector i/wpv, group i%wpv.
    function automatic logic [63:0] model_word(input int dim, input int i);
        int wpv, v, g;
        logic [63:0] w;
        wpv = dim / 4;
        v   = i / wpv;
        g   = i % wpv;
        w   = '0;
        for (int k = 0; k < 4; k++) begin
            w[16*k +: 8]     = qv[4*g + k];
            w[16*k + 8 +: 8] = cv[v*dim + 4*g + k];
        end
        return w;
    endfunction

    task automatic run_load(input int dim, input int vc, input int stall, input int exp_words);
        bit ok;
        wq.delete();
        pulse_start(dim, vc);
        check("start_busy", 64'(busy), 64'd1);
        check("start_ready", 64'(bus.s_ready), 64'd1);
        for (int i = 0; i < dim; i++) begin
            send_byte(qv[i], stall, ok);
            if (!ok) begin
                check("query_stream_timeout", 64'd0, 64'd1);
                return;
            end
        end
        for (int i = 0; i < vc * dim; i++) begin
            send_byte(cv[i], stall, ok);
            if (!ok) begin
                check("cand_stream_timeout", 64'd0, 64'd1);
                return;
            end
        end
        // One cycle after the last byte: final write, no done yet.
        check("flush_we", 64'(bus.mem_we), 64'd1);
        check("flush_done_low", 64'(done), 64'd0);
        step();
        check("done_pulse", 64'(done), 64'd1);
        check("words_written", 64'(words_written), 64'(exp_words % 4096));
        step();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        check("word_count", 64'(wq.size()), 64'(exp_words));
        for (int i = 0; i < wq.size(); i++) begin
            check("waddr", 64'(wq[i].a), 64'(i));
            check("wdata", wq[i].d, model_word(dim, i));
        end
    endtask

    task automatic run_err(input int dim, input int vc);
        int dc;
        wq.delete();
        dc = done_cnt;
        pulse_start(dim, vc);
        check("cfg_err_pulse", 64'(cfg_err), 64'd1);
        check("cfg_err_busy", 64'(busy), 64'd0);
        check("cfg_err_ready", 64'(bus.s_ready), 64'd0);
        repeat (3) step();
        check("cfg_err_clear", 64'(cfg_err), 64'd0);
        check("cfg_err_no_write", 64'(wq.size()), 64'd0);
        check("cfg_err_no_done", 64'(done_cnt - dc), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, rc;
        bit ok;

        tbl[0] = '{6,   1,  0, 1'b1, 0};
        tbl[1] = '{0,   1,  0, 1'b1, 0};
        tbl[2] = '{252, 69, 0, 1'b1, 0};
        tbl[3] = '{12,  1, 30, 1'b0, 3};
        tbl[4] = '{4,   3, 50, 1'b0, 3};
        tbl[5] = '{16,  5, 20, 1'b0, 20};
        tbl[6] = '{8,   2,  0, 1'b0, 4};
        tbl[7] = '{252, 1, 10, 1'b0, 63};
        tbl[8] = '{20,  7, 25, 1'b0, 35};

        reset        = 1'b1;
        start_load   = 1'b0;
        dim_size     = 8'd0;
        vector_count = 10'd0;
        bus.s_valid  = 1'b0;
        bus.s_data   = 8'd0;
        repeat (2) step();

        // Reset state
        check("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_waddr", 64'(bus.mem_waddr), 64'd0);
        check("rst_mem_wdata", bus.mem_wdata, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        check("rst_words_written", 64'(words_written), 64'd0);
        reset = 1'b0;
        step();

        // Directed reference vector
        for (int i = 0; i < 8; i++) begin
            qv[i] = 8'(i + 1);
            cv[i] = 8'(8'h10 + i);
        end
        run_load(8, 1, 0, 2);
        check("basic_count", 64'(wq.size()), 64'd2);
        if (wq.size() >= 2) begin
            check("basic_word0", wq[0].d, 64'h1304_1203_1102_1001);
            check("basic_word1", wq[1].d, 64'h1708_1607_1506_1405);
            check("basic_addr1", 64'(wq[1].a), 64'd1);
        end

        // Table of configurations, random data
        for (int i = 0; i < NT; i++) begin
            fill_random();
            if (tbl[i].err) run_err(tbl[i].dim, tbl[i].vc);
            else            run_load(tbl[i].dim, tbl[i].vc, tbl[i].stall, tbl[i].words);
        end

        // Stalled stream must give the same words as an unstalled one
        fill_random();
        run_load(4, 3, 0, 3);
        ref_q = wq;
        run_load(4, 3, 60, 3);
        check("stall_count", 64'(wq.size()), 64'(ref_q.size()));
        for (int i = 0; i < wq.size() && i < ref_q.size(); i++) begin
            check("stall_addr", 64'(wq[i].a), 64'(ref_q[i].a));
            check("stall_data", wq[i].d, ref_q[i].d);
        end

        // Largest legal load: 4095 words
        fill_random();
        run_load(252, 65, 0, 4095);
        if (wq.size() > 0) check("last_addr", 64'(wq[wq.size()-1].a), 64'd4094);

        // vector_count == 0: straight to done, no stream, no writes
        wq.delete();
        dc = done_cnt;
        rc = ready_cnt;
        pulse_start(8, 0);
        repeat (3) step();
        check("vc0_done", 64'(done_cnt - dc), 64'd1);
        check("vc0_no_ready", 64'(ready_cnt - rc), 64'd0);
        check("vc0_no_write", 64'(wq.size()), 64'd0);
        check("vc0_busy", 64'(busy), 64'd0);

        // Reset after 5 candidate bytes
        fill_random();
        wq.delete();
        pulse_start(8, 2);
        for (int i = 0; i < 13; i++) begin
            send_byte(i < 8 ? qv[i] : cv[i-8], 0, ok);
            if (!ok) check("rst_seq_timeout", 64'd0, 64'd1);
        end
        check("pre_reset_writes", 64'(wq.size()), 64'd1);
        check("pre_reset_words", 64'(words_written), 64'd1);
        dc = done_cnt;
        #1 reset = 1'b1;
        #1;
        check("async_rst_we", 64'(bus.mem_we), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_ready", 64'(bus.s_ready), 64'd0);
        check("async_rst_words", 64'(words_written), 64'd0);
        step();
        reset = 1'b0;
        repeat (4) step();
        check("rst_no_done", 64'(done_cnt - dc), 64'd0);
        run_load(8, 1, 20, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
